// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard/event bundle between the pipeline stages and the hazard controller.
// Requests flow from the pipeline (master) to the controller (slave); the
// controller returns per-stage stall/flush vectors, PC redirect and perf counters.
interface pipe_hazard_ctrl_if #(
  parameter int NSTAGES = 5,
  parameter int XLEN    = 32,
  parameter int CNT_W   = 32
);
  // requests from ID / EXE / MEM
  logic               loaduse_hazard_i;
  logic               branch_taken_i;
  logic [XLEN-1:0]    branch_target_i;
  logic               exe_busy_i;
  logic               mem_req_i;
  logic               mem_ready_i;
  // controls back to the pipeline registers and PC
  logic [NSTAGES-1:0] stall_o;
  logic [NSTAGES-1:0] flush_o;
  logic               redirect_o;
  logic [XLEN-1:0]    redirect_pc_o;
  logic [CNT_W-1:0]   stall_cnt_o;
  logic [CNT_W-1:0]   flush_cnt_o;

  modport master (
    output loaduse_hazard_i, branch_taken_i, branch_target_i,
           exe_busy_i, mem_req_i, mem_ready_i,
    input  stall_o, flush_o, redirect_o, redirect_pc_o,
           stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  loaduse_hazard_i, branch_taken_i, branch_target_i,
           exe_busy_i, mem_req_i, mem_ready_i,
    output stall_o, flush_o, redirect_o, redirect_pc_o,
           stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: prioritised mem-wait / exe-busy / redirect / load-use
// stall+flush generation, wrong-path fetch shadow flush, and stall/flush perf counters.
// Ports: clk_i, rst_i (sync, active-high), hz = slave side of pipe_hazard_ctrl_if.
// Outputs are combinational (zero latency); FSM, shadow counter and counters update on clk_i.
module pipe_hazard_ctrl #(
  parameter int NSTAGES   = 5,
  parameter int ID_STAGE  = 1,
  parameter int EXE_STAGE = 2,
  parameter int MEM_STAGE = 3,
  parameter int XLEN      = 32,
  parameter int MEM_WAIT  = 0,
  parameter int FETCH_LAT = 1,
  parameter int CNT_W     = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  pipe_hazard_ctrl_if.slave hz
);

  typedef enum logic {RUN, MWAIT} state_e;

  // wait counter preload: the RUN cycle that detects the access already counts as one wait
  localparam logic [3:0] WCNT_LOAD  = (MEM_WAIT > 0) ? 4'(MEM_WAIT - 1) : 4'd0;
  localparam logic [1:0] SHCNT_LOAD = 2'(FETCH_LAT);

  state_e             state_q, state_d;
  logic [3:0]         wcnt_q, wcnt_d;
  logic [1:0]         shcnt_q, shcnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

  logic               memstall;
  logic               exestall;
  logic               redirect;
  logic               loaduse;
  logic [NSTAGES-1:0] stall;
  logic [NSTAGES-1:0] flush;

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    shcnt_d     = shcnt_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    stall       = '0;
    flush       = '0;

    // mem stall: a fresh access in RUN, or an outstanding one in MWAIT
    if (state_q == RUN)
      memstall = hz.mem_req_i && ((MEM_WAIT > 0) || !hz.mem_ready_i);
    else
      memstall = (wcnt_q != 4'd0) || !hz.mem_ready_i;

    exestall = !memstall && hz.exe_busy_i;
    redirect = !memstall && !exestall && hz.branch_taken_i;
    loaduse  = !memstall && !exestall && !redirect && hz.loaduse_hazard_i;

    for (int k = 0; k < NSTAGES; k++) begin
      if (memstall) begin
        if (k <= MEM_STAGE)     stall[k] = 1'b1;
        if (k == MEM_STAGE + 1) flush[k] = 1'b1;
      end else if (exestall) begin
        if (k <= EXE_STAGE)     stall[k] = 1'b1;
        if (k == EXE_STAGE + 1) flush[k] = 1'b1;
      end else if (redirect) begin
        if (k < EXE_STAGE)      flush[k] = 1'b1;
      end else if (loaduse) begin
        if (k < ID_STAGE)       stall[k] = 1'b1;
        if (k == ID_STAGE)      flush[k] = 1'b1;
      end
    end

    // wrong-path fetch shadow: kill IF output while fetches issued before the
    // redirect drain; a held IF register keeps its wrong-path word, so hold shcnt
    if (redirect) begin
      shcnt_d = SHCNT_LOAD;
    end else if (shcnt_q != 2'd0 && !stall[0]) begin
      flush[0] = 1'b1;
      shcnt_d  = shcnt_q - 2'd1;
    end

    // memory wait FSM
    case (state_q)
      RUN: begin
        if (memstall) begin
          state_d = MWAIT;
          wcnt_d  = WCNT_LOAD;
        end
      end
      MWAIT: begin
        if (!memstall)
          state_d = RUN;
        else if (wcnt_q != 4'd0)
          wcnt_d = wcnt_q - 4'd1;
      end
      default: state_d = RUN;
    endcase

    if (stall[0]) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (redirect) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= RUN;
      wcnt_q      <= 4'd0;
      shcnt_q     <= 2'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      shcnt_q     <= shcnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // during reset every stage register loads a bubble and nothing holds
  assign hz.stall_o       = rst_i ? '0 : stall;
  assign hz.flush_o       = rst_i ? '1 : flush;
  assign hz.redirect_o    = rst_i ? 1'b0 : redirect;
  assign hz.redirect_pc_o = hz.branch_target_i;
  assign hz.stall_cnt_o   = stall_cnt_q;
  assign hz.flush_cnt_o   = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: three instances (MEM_WAIT 0/2/3) share one stimulus.
// Table-driven single-cycle vectors on the MEM_WAIT=0 instance, then hand
// sequences for fixed/variable mem waits, exe-busy with held branch, and reset mid-access.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        lu, br, busy, req, rdy;
  logic [31:0] tgt;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.NSTAGES(5), .XLEN(32), .CNT_W(32)) if0 ();
  pipe_hazard_ctrl_if #(.NSTAGES(5), .XLEN(32), .CNT_W(32)) if2 ();
  pipe_hazard_ctrl_if #(.NSTAGES(5), .XLEN(32), .CNT_W(32)) if3 ();

  assign if0.loaduse_hazard_i = lu;   assign if2.loaduse_hazard_i = lu;   assign if3.loaduse_hazard_i = lu;
  assign if0.branch_taken_i   = br;   assign if2.branch_taken_i   = br;   assign if3.branch_taken_i   = br;
  assign if0.branch_target_i  = tgt;  assign if2.branch_target_i  = tgt;  assign if3.branch_target_i  = tgt;
  assign if0.exe_busy_i       = busy; assign if2.exe_busy_i       = busy; assign if3.exe_busy_i       = busy;
  assign if0.mem_req_i        = req;  assign if2.mem_req_i        = req;  assign if3.mem_req_i        = req;
  assign if0.mem_ready_i      = rdy;  assign if2.mem_ready_i      = rdy;  assign if3.mem_ready_i      = rdy;

  pipe_hazard_ctrl #(.MEM_WAIT(0), .FETCH_LAT(1)) dut0 (.clk_i(clk), .rst_i(rst), .hz(if0.slave));
  pipe_hazard_ctrl #(.MEM_WAIT(2), .FETCH_LAT(1)) dut2 (.clk_i(clk), .rst_i(rst), .hz(if2.slave));
  pipe_hazard_ctrl #(.MEM_WAIT(3), .FETCH_LAT(1)) dut3 (.clk_i(clk), .rst_i(rst), .hz(if3.slave));

  typedef struct {
    logic        lu, br, busy, req, rdy;
    logic [31:0] tgt;
    logic [4:0]  stall, flush;
    logic        red;
  } vec_t;

  vec_t tbl[13];

  function automatic vec_t mk(logic l, logic b, logic bz, logic rq, logic rd,
                              logic [31:0] t, logic [4:0] s, logic [4:0] f, logic r);
    vec_t v;
    v.lu = l; v.br = b; v.busy = bz; v.req = rq; v.rdy = rd;
    v.tgt = t; v.stall = s; v.flush = f; v.red = r;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic set_in(input logic l, input logic b, input logic bz,
                        input logic rq, input logic rd, input logic [31:0] t);
    lu = l; br = b; busy = bz; req = rq; rdy = rd; tgt = t;
  endtask

  // advance to 1 time unit after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // one reset cycle, checking reset outputs; returns with rst low right after the edge
  task automatic do_reset();
    cyc();
    rst = 1'b1;
    set_in(0, 0, 0, 0, 1, 32'h0);
    #3;
    chk("rst_stall", 32'(if0.stall_o), 32'h00);
    chk("rst_flush", 32'(if0.flush_o), 32'h1f);
    chk("rst_redir", 32'(if0.redirect_o), 32'h0);
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    set_in(0, 0, 0, 0, 1, 32'h0);

    //               lu br bz rq rd  tgt          stall     flush     red
    tbl[0]  = mk(0, 0, 0, 0, 1, 32'h0,    5'b00000, 5'b00000, 0);
    tbl[1]  = mk(1, 0, 0, 0, 1, 32'h0,    5'b00001, 5'b00010, 0); // load-use
    tbl[2]  = mk(1, 1, 0, 0, 1, 32'h80,   5'b00000, 5'b00011, 1); // redirect beats load-use
    tbl[3]  = mk(1, 0, 0, 0, 1, 32'h0,    5'b00001, 5'b00010, 0); // shadow held by IF stall
    tbl[4]  = mk(0, 0, 0, 0, 1, 32'h0,    5'b00000, 5'b00001, 0); // shadow flush
    tbl[5]  = mk(0, 0, 0, 0, 1, 32'h0,    5'b00000, 5'b00000, 0);
    tbl[6]  = mk(0, 1, 1, 0, 1, 32'h40,   5'b00111, 5'b01000, 0); // exe busy holds branch
    tbl[7]  = mk(0, 0, 1, 1, 1, 32'h0,    5'b00111, 5'b01000, 0); // MEM_WAIT=0 ready: no mem stall
    tbl[8]  = mk(0, 1, 1, 1, 0, 32'h0,    5'b01111, 5'b10000, 0); // mem not ready wins
    tbl[9]  = mk(0, 0, 0, 1, 0, 32'h0,    5'b01111, 5'b10000, 0);
    tbl[10] = mk(0, 1, 0, 1, 1, 32'h1234, 5'b00000, 5'b00011, 1); // release cycle, redirect
    tbl[11] = mk(0, 0, 0, 0, 1, 32'h0,    5'b00000, 5'b00001, 0);
    tbl[12] = mk(0, 0, 0, 0, 1, 32'h0,    5'b00000, 5'b00000, 0);

    do_reset();
    chk("rst_stall_cnt", if0.stall_cnt_o, 32'd0);
    chk("rst_flush_cnt", if0.flush_cnt_o, 32'd0);

    for (int i = 0; i < 13; i++) begin
      if (i > 0) cyc();
      set_in(tbl[i].lu, tbl[i].br, tbl[i].busy, tbl[i].req, tbl[i].rdy, tbl[i].tgt);
      #3;
      chk($sformatf("vec%0d_stall", i), 32'(if0.stall_o), 32'(tbl[i].stall));
      chk($sformatf("vec%0d_flush", i), 32'(if0.flush_o), 32'(tbl[i].flush));
      chk($sformatf("vec%0d_redir", i), 32'(if0.redirect_o), 32'(tbl[i].red));
      if (tbl[i].red) chk($sformatf("vec%0d_pc", i), if0.redirect_pc_o, tbl[i].tgt);
    end
    cyc();
    set_in(0, 0, 0, 0, 1, 32'h0);
    #3;
    chk("tbl_stall_cnt", if0.stall_cnt_o, 32'd6);
    chk("tbl_flush_cnt", if0.flush_cnt_o, 32'd2);

    // fixed wait: MEM_WAIT=2, ready high -> two stall cycles then release
    do_reset();
    set_in(0, 0, 0, 1, 1, 32'h0);
    #3;
    chk("mw2_c0_stall", 32'(if2.stall_o), 32'h0f);
    chk("mw2_c0_flush", 32'(if2.flush_o), 32'h10);
    chk("mw0_c0_stall", 32'(if0.stall_o), 32'h00);
    cyc(); #3;
    chk("mw2_c1_stall", 32'(if2.stall_o), 32'h0f);
    chk("mw2_c1_flush", 32'(if2.flush_o), 32'h10);
    cyc(); #3;
    chk("mw2_rel_stall", 32'(if2.stall_o), 32'h00);
    chk("mw2_rel_flush", 32'(if2.flush_o), 32'h00);
    cyc();
    set_in(0, 0, 0, 0, 1, 32'h0);
    #3;
    chk("mw2_idle_stall", 32'(if2.stall_o), 32'h00);
    chk("mw2_stall_cnt", if2.stall_cnt_o, 32'd2);

    // variable wait: MEM_WAIT=0, ready low 3 cycles, then back-to-back access
    do_reset();
    for (int c = 0; c < 3; c++) begin
      if (c > 0) cyc();
      set_in(0, 0, 0, 1, 0, 32'h0);
      #3;
      chk($sformatf("var_c%0d_stall", c), 32'(if0.stall_o), 32'h0f);
    end
    cyc();
    set_in(0, 0, 0, 1, 1, 32'h0);
    #3;
    chk("var_rel_stall", 32'(if0.stall_o), 32'h00);
    cyc();
    set_in(0, 0, 0, 1, 0, 32'h0);
    #3;
    chk("b2b_stall", 32'(if0.stall_o), 32'h0f);
    cyc();
    set_in(0, 0, 0, 1, 1, 32'h0);
    #3;
    chk("b2b_rel_stall", 32'(if0.stall_o), 32'h00);
    cyc();
    set_in(0, 0, 0, 0, 1, 32'h0);
    #3;
    chk("var_run_stall", 32'(if0.stall_o), 32'h00);
    chk("var_stall_cnt", if0.stall_cnt_o, 32'd4);

    // exe busy 4 cycles with branch held; redirect fires once in cycle 5
    do_reset();
    for (int c = 0; c < 4; c++) begin
      if (c > 0) cyc();
      set_in(0, 1, 1, 0, 1, 32'h200);
      #3;
      chk($sformatf("exe_c%0d_stall", c), 32'(if0.stall_o), 32'h07);
      chk($sformatf("exe_c%0d_flush", c), 32'(if0.flush_o), 32'h08);
      chk($sformatf("exe_c%0d_redir", c), 32'(if0.redirect_o), 32'h0);
    end
    cyc();
    set_in(0, 1, 0, 0, 1, 32'h200);
    #3;
    chk("exe_c4_redir", 32'(if0.redirect_o), 32'h1);
    chk("exe_c4_flush", 32'(if0.flush_o), 32'h03);
    chk("exe_c4_pc", if0.redirect_pc_o, 32'h200);
    cyc();
    set_in(0, 0, 0, 0, 1, 32'h0);
    #3;
    chk("exe_shadow_flush", 32'(if0.flush_o), 32'h01);
    chk("exe_flush_cnt", if0.flush_cnt_o, 32'd1);

    // reset in the middle of a MEM_WAIT=3 access
    do_reset();
    set_in(0, 0, 0, 1, 1, 32'h0);
    #3;
    chk("mw3_c0_stall", 32'(if3.stall_o), 32'h0f);
    cyc();
    rst = 1'b1;
    #3;
    chk("mw3_rst_stall", 32'(if3.stall_o), 32'h00);
    chk("mw3_rst_flush", 32'(if3.flush_o), 32'h1f);
    chk("mw3_rst_redir", 32'(if3.redirect_o), 32'h0);
    cyc();
    rst = 1'b0;
    set_in(0, 0, 0, 0, 1, 32'h0);
    #3;
    chk("mw3_post_stall", 32'(if3.stall_o), 32'h00);
    chk("mw3_post_flush", 32'(if3.flush_o), 32'h00);
    chk("mw3_post_scnt", if3.stall_cnt_o, 32'd0);
    chk("mw3_post_fcnt", if3.flush_cnt_o, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
